rv_multicore_fsm: RTL and testbench
===================================

# rv_multicore_fsm

Parametrised multi-cycle RV subset core, the successor to the fixed 64-bit pipelined core. XLEN is selectable (32/64) and the address width is configurable. Both memory ports use a `cs`/`ready` handshake, so memories may insert wait states. An illegal opcode halts the core. It sits between the program-memory and data-memory blocks, in place of the pipelined core, on designs that need wait-state memories.

## Interface
- XLEN, 64, datapath/register width; legal values 32 or 64.
- ADDR_W, 10, memory address width; PC is truncated to this width on output.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_pm_addr  out  ADDR_W  byte address of the instruction (PC[ADDR_W-1:0]).
- o_pm_cs  out  1  fetch request.
- i_pm_ready  in  1  fetch data valid this cycle.
- i_pm_data  in  32  instruction, byte-reversed: instr[7:0]=i_pm_data[31:24] … instr[31:24]=i_pm_data[7:0].
- o_dm_addr  out  ADDR_W  data byte address (ALU result, truncated).
- o_dm_cs  out  1  data request.
- o_dm_rw  out  1  1=write, 0=read; valid only while o_dm_cs=1.
- o_dm_data  out  XLEN  store data, byte-reversed over XLEN/8 bytes.
- i_dm_ready  in  1  data access complete this cycle.
- i_dm_data  in  XLEN  load data, byte-reversed as for o_dm_data.
- o_retire  out  1  one-cycle pulse per completed instruction.
- o_halt  out  1  sticky; set on an illegal instruction.

## Operation
- **Internal state:** 32×XLEN register file. x0 reads 0 and writes to it are dropped.
- **States:** FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH:** o_pm_cs=1 and o_pm_addr=PC are held until i_pm_ready=1. At that edge the instruction is latched and the state goes to DECODE.
- **DECODE:** reads rs1/rs2 and generates the immediate (I, S, B formats, sign-extended to XLEN).
- **Legal instruction set:**
  - opcode 0110011: add/sub/and/or (funct7 bit30 selects sub).
  - opcode 0010011: addi/andi/ori.
  - opcode 0000011 load: funct3=011 when XLEN=64, 010 when XLEN=32.
  - opcode 0100011 store: same funct3 rule as load.
  - opcode 1100011: beq (funct3 000) and bne (001).
  - Anything else is illegal.
- **Illegal instruction:** DECODE→HALT; o_halt=1; no further requests are issued until reset.
- **EXEC:**
  - Computes the ALU result, or the address rs1+imm for loads/stores.
  - Branch: PC ← taken ? PC+imm13 : PC+4. Then FETCH with o_retire=1 at that edge.
- **MEM:** o_dm_cs=1; o_dm_rw=store; address and data are held until i_dm_ready=1.
  - Store: PC+=4 → FETCH, with retire.
  - Load: data is latched → WB.
- **WB:** rd ← result; PC+=4 → FETCH, with retire.
- **Arithmetic:** modulo 2^XLEN. Address/PC arithmetic is XLEN wide; only the outputs are truncated to ADDR_W.
- **Ready outside a request:** ready inputs are ignored whenever the matching cs is 0.

## Timing
- **Output decoding:** all outputs are decoded from registered state. cs is never asserted combinationally from ready.
- **Latency with ready tied 1 (FETCH→FETCH):**
  - branch 3 cycles.
  - ALU/immediate 4 cycles.
  - store 4 cycles.
  - load 5 cycles.
- **Wait states:** each wait cycle adds one cycle; address, rw and data stay stable throughout.
- **Reset:** takes priority over everything, including a pending handshake.
  - Following edge: state=FETCH, PC=RESET_PC, all registers 0.
  - Outputs during the reset cycle: o_pm_cs=1 (FETCH), o_dm_cs=0, o_dm_rw=0, o_dm_data=0, o_retire=0, o_halt=0.
  - An access in flight when reset is asserted is abandoned.
- **PC wrap:** PC wraps at 2^XLEN. o_pm_addr wraps at 2^ADDR_W with no fault.
- **Same-register dependence:** no hazard is possible, because each instruction completes before the next fetch.

## Test plan
- **ALU sequence:** reset with ready=1; run addi x1,x0,5 / addi x2,x0,7 / add x3,x1,x2 / sd x3,8(x0).
  - Store cycle shows o_dm_cs=1, o_dm_rw=1, o_dm_addr=8, o_dm_data=0x0C00000000000000.
  - o_retire pulses 4 times at 4-cycle spacing.
- **Load:** ld x4,8(x0) with i_dm_data=0x0C00000000000000, then sd x4,16(x0).
  - Store data is 0x0C00000000000000 at address 16.
  - Load takes exactly 5 cycles.
- **Wait states:** hold i_pm_ready=0 for 3 cycles, then i_dm_ready=0 for 2 cycles.
  - o_pm_addr and o_dm_addr/rw/data stay constant.
  - Instruction latency grows by exactly 5.
- **Branches:** at PC=0x10, beq x1,x1,-8 → next o_pm_addr=0x08. bne x1,x1,-8 → next o_pm_addr=0x14.
- **Illegal opcode and x0:**
  - Fetch 0x00000000 → o_halt=1 from the cycle after DECODE; cs stays 0 for 20 cycles; i_rst clears it and o_pm_addr=RESET_PC.
  - addi x0,x0,9 then sd x0,0(x0) → o_dm_data=0.
- **XLEN=32 build:** sw/lw work with o_dm_data=0x0C000000 for value 12. The ld encoding halts. Reset asserted during MEM drops o_dm_cs on the next edge.

Source files
------------

// File: rtl/rv_multicore_fsm.sv
// Multi-cycle RV subset core (add/sub/and/or, addi/andi/ori, XLEN-wide load/store, beq/bne)
// with cs/ready handshakes on both memory ports; an illegal instruction halts until reset.
module rv_multicore_fsm #(
  parameter int XLEN = 64,
  parameter int ADDR_W = 10,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_pm_addr,
  output logic              o_pm_cs,
  input  logic              i_pm_ready,
  input  logic [31:0]       i_pm_data,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic              o_dm_cs,
  output logic              o_dm_rw,
  output logic [XLEN-1:0]   o_dm_data,
  input  logic              i_dm_ready,
  input  logic [XLEN-1:0]   i_dm_data,
  output logic              o_retire,
  output logic              o_halt
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;

  state_t          state, state_next;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_val, rs2_val, imm, result;
  logic            retire;
  logic [XLEN-1:0] regs [32];

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic            is_rtype, is_itype, is_load, is_store, is_branch, legal;
  logic [XLEN-1:0] imm_gen, alu_b, alu_out, pc_plus4;
  logic            taken;

  // Memory data travels with its bytes in reverse order.
  function automatic logic [XLEN-1:0] bswap(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = '0;
    for (int k = 0; k < XLEN / 8; k++) r[8*k +: 8] = v[XLEN-8-8*k +: 8];
    return r;
  endfunction

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign is_rtype  = (opcode == 7'b0110011);
  assign is_itype  = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011);

  always_comb begin
    legal = 1'b0;
    if (is_rtype)
      legal = ((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
              (((funct3 == 3'b111) || (funct3 == 3'b110)) && (funct7 == 7'b0000000));
    else if (is_itype)
      legal = (funct3 == 3'b000) || (funct3 == 3'b111) || (funct3 == 3'b110);
    else if (is_load || is_store)
      legal = (funct3 == LS_F3);
    else if (is_branch)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001);
  end

  always_comb begin
    imm_gen = {{(XLEN-12){instr[31]}}, instr[31:20]};
    if (is_store)
      imm_gen = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    else if (is_branch)
      imm_gen = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  end

  always_comb begin
    alu_b   = is_rtype ? rs2_val : imm;
    alu_out = rs1_val + alu_b;
    if (is_rtype && (funct3 == 3'b000) && instr[30])
      alu_out = rs1_val - alu_b;
    else if ((is_rtype || is_itype) && (funct3 == 3'b111))
      alu_out = rs1_val & alu_b;
    else if ((is_rtype || is_itype) && (funct3 == 3'b110))
      alu_out = rs1_val | alu_b;
  end

  assign pc_plus4 = pc + XLEN'(4);
  assign taken    = funct3[0] ? (rs1_val != rs2_val) : (rs1_val == rs2_val);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (i_pm_ready) state_next = DECODE;
      DECODE: state_next = legal ? EXEC : HALT;
      EXEC: begin
        if (is_branch)                 state_next = FETCH;
        else if (is_load || is_store)  state_next = MEM;
        else                           state_next = WB;
      end
      MEM:    if (i_dm_ready) state_next = is_store ? FETCH : WB;
      WB:     state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Datapath registers advance with the state they belong to; retire is a registered pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc      <= RESET_PC;
      instr   <= '0;
      rs1_val <= '0;
      rs2_val <= '0;
      imm     <= '0;
      result  <= '0;
      retire  <= 1'b0;
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: if (i_pm_ready)
          instr <= {i_pm_data[7:0], i_pm_data[15:8], i_pm_data[23:16], i_pm_data[31:24]};
        DECODE: begin
          rs1_val <= (rs1 == 5'd0) ? '0 : regs[rs1];
          rs2_val <= (rs2 == 5'd0) ? '0 : regs[rs2];
          imm     <= imm_gen;
        end
        EXEC: begin
          if (is_branch) begin
            pc     <= taken ? (pc + imm) : pc_plus4;
            retire <= 1'b1;
          end else begin
            result <= alu_out;
          end
        end
        MEM: if (i_dm_ready) begin
          if (is_store) begin
            pc     <= pc_plus4;
            retire <= 1'b1;
          end else begin
            result <= bswap(i_dm_data);
          end
        end
        WB: begin
          if (rd != 5'd0) regs[rd] <= result;
          pc     <= pc_plus4;
          retire <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_pm_cs   = (state == FETCH);
  assign o_pm_addr = pc[ADDR_W-1:0];
  assign o_dm_cs   = (state == MEM);
  assign o_dm_rw   = o_dm_cs && is_store;
  assign o_dm_addr = result[ADDR_W-1:0];
  assign o_dm_data = o_dm_cs ? bswap(rs2_val) : '0;
  assign o_retire  = retire;
  assign o_halt    = (state == HALT);

endmodule

// File: tb/tb_rv_multicore_fsm.sv
// Directed bench for rv_multicore_fsm: a 64-bit and a 32-bit instance, each fed from a
// small program array, with handshake, branch, halt and reset behaviour checked by assertions.
module tb_rv_multicore_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_64, pm_cs_64, pm_ready_64, dm_cs_64, dm_rw_64, dm_ready_64, retire_64, halt_64;
  logic [9:0]  pm_addr_64, dm_addr_64;
  logic [31:0] pm_data_64;
  logic [63:0] dm_wdata_64, dm_rdata_64;

  logic        rst_32, pm_cs_32, pm_ready_32, dm_cs_32, dm_rw_32, dm_ready_32, retire_32, halt_32;
  logic [9:0]  pm_addr_32, dm_addr_32;
  logic [31:0] pm_data_32;
  logic [31:0] dm_wdata_32, dm_rdata_32;

  logic [31:0] prog_64 [0:31];
  logic [31:0] prog_32 [0:31];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0;
  logic any_cs;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign pm_data_64 = bswap32(prog_64[pm_addr_64[6:2]]);
  assign pm_data_32 = bswap32(prog_32[pm_addr_32[6:2]]);

  rv_multicore_fsm #(.XLEN(64), .ADDR_W(10)) dut64 (
    .i_clk(clk), .i_rst(rst_64),
    .o_pm_addr(pm_addr_64), .o_pm_cs(pm_cs_64), .i_pm_ready(pm_ready_64), .i_pm_data(pm_data_64),
    .o_dm_addr(dm_addr_64), .o_dm_cs(dm_cs_64), .o_dm_rw(dm_rw_64), .o_dm_data(dm_wdata_64),
    .i_dm_ready(dm_ready_64), .i_dm_data(dm_rdata_64),
    .o_retire(retire_64), .o_halt(halt_64)
  );

  rv_multicore_fsm #(.XLEN(32), .ADDR_W(10)) dut32 (
    .i_clk(clk), .i_rst(rst_32),
    .o_pm_addr(pm_addr_32), .o_pm_cs(pm_cs_32), .i_pm_ready(pm_ready_32), .i_pm_data(pm_data_32),
    .o_dm_addr(dm_addr_32), .o_dm_cs(dm_cs_32), .o_dm_rw(dm_rw_32), .o_dm_data(dm_wdata_32),
    .i_dm_ready(dm_ready_32), .i_dm_data(dm_rdata_32),
    .o_retire(retire_32), .o_halt(halt_32)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("[TB] %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic probe(input int which);
    case (which)
      0: return retire_64;
      1: return dm_cs_64;
      2: return retire_32;
      default: return dm_cs_32;
    endcase
  endfunction

  // Steps until the selected signal is seen high, giving up after 40 cycles.
  task automatic wait_for(input string tag, input int which);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = probe(which);
    end
    check_output(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      prog_64[i] = 32'h0;
      prog_32[i] = 32'h0;
    end
    prog_64[0] = 32'h00500093;  // addi x1,x0,5
    prog_64[1] = 32'h00700113;  // addi x2,x0,7
    prog_64[2] = 32'h002081B3;  // add  x3,x1,x2
    prog_64[3] = 32'h00303423;  // sd   x3,8(x0)
    prog_64[4] = 32'h00803203;  // ld   x4,8(x0)
    prog_64[5] = 32'h00403823;  // sd   x4,16(x0)
    prog_64[6] = 32'h00303C23;  // sd   x3,24(x0)
    prog_32[0] = 32'h00C00093;  // addi x1,x0,12
    prog_32[1] = 32'h00102223;  // sw   x1,4(x0)
    prog_32[2] = 32'h00402103;  // lw   x2,4(x0)
    prog_32[3] = 32'h00202423;  // sw   x2,8(x0)
    prog_32[4] = 32'h00803183;  // ld   x3,8(x0)
    rst_64 = 1'b1; rst_32 = 1'b1;
    pm_ready_64 = 1'b1; dm_ready_64 = 1'b1; pm_ready_32 = 1'b1; dm_ready_32 = 1'b1;
    dm_rdata_64 = 64'h0C00000000000000;
    dm_rdata_32 = 32'h0C000000;
    $display("[TB] start");
    step(); step();

    check_output("rst pm_cs", 64'(pm_cs_64), 64'd1);
    check_output("rst pm_addr", 64'(pm_addr_64), 64'd0);
    check_output("rst dm_cs", 64'(dm_cs_64), 64'd0);
    check_output("rst dm_rw", 64'(dm_rw_64), 64'd0);
    check_output("rst dm_data", dm_wdata_64, 64'd0);
    check_output("rst retire", 64'(retire_64), 64'd0);
    check_output("rst halt", 64'(halt_64), 64'd0);
    rst_64 = 1'b0;

    t0 = cyc; wait_for("retire addi x1", 0); check_output("lat addi x1", 64'(cyc - t0), 64'd4);
    t0 = cyc; wait_for("retire addi x2", 0); check_output("lat addi x2", 64'(cyc - t0), 64'd4);
    t0 = cyc; wait_for("retire add x3", 0);  check_output("lat add x3", 64'(cyc - t0), 64'd4);

    t0 = cyc; wait_for("cs sd x3", 1);
    check_output("sd x3 rw", 64'(dm_rw_64), 64'd1);
    check_output("sd x3 addr", 64'(dm_addr_64), 64'd8);
    check_output("sd x3 data", dm_wdata_64, 64'h0C00000000000000);
    wait_for("retire sd x3", 0); check_output("lat sd x3", 64'(cyc - t0), 64'd4);

    t0 = cyc; wait_for("cs ld x4", 1);
    check_output("ld x4 rw", 64'(dm_rw_64), 64'd0);
    check_output("ld x4 addr", 64'(dm_addr_64), 64'd8);
    wait_for("retire ld x4", 0); check_output("lat ld x4", 64'(cyc - t0), 64'd5);

    t0 = cyc; wait_for("cs sd x4", 1);
    check_output("sd x4 addr", 64'(dm_addr_64), 64'd16);
    check_output("sd x4 data", dm_wdata_64, 64'h0C00000000000000);
    wait_for("retire sd x4", 0); check_output("lat sd x4", 64'(cyc - t0), 64'd4);

    // Three fetch wait cycles then two data wait cycles on sd x3,24(x0).
    t0 = cyc; pm_ready_64 = 1'b0; dm_ready_64 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("wait pm_addr", 64'(pm_addr_64), 64'h18);
      check_output("wait pm_cs", 64'(pm_cs_64), 64'd1);
    end
    pm_ready_64 = 1'b1;
    wait_for("cs wait sd", 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_output("wait dm_cs", 64'(dm_cs_64), 64'd1);
      check_output("wait dm_addr", 64'(dm_addr_64), 64'd24);
      check_output("wait dm_rw", 64'(dm_rw_64), 64'd1);
      check_output("wait dm_data", dm_wdata_64, 64'h0C00000000000000);
    end
    dm_ready_64 = 1'b1;
    wait_for("retire wait sd", 0); check_output("lat wait sd", 64'(cyc - t0), 64'd9);

    rst_64 = 1'b1;
    prog_64[0] = 32'h00300093;  // addi x1,x0,3
    prog_64[1] = 32'h00000013;
    prog_64[2] = 32'h00000013;
    prog_64[3] = 32'h00000013;
    prog_64[4] = 32'hFE108CE3;  // beq x1,x1,-8
    prog_64[5] = 32'h00900013;  // addi x0,x0,9
    prog_64[6] = 32'h00003023;  // sd x0,0(x0)
    prog_64[7] = 32'h00000000;
    step();
    rst_64 = 1'b0;
    for (int i = 0; i < 4; i++) wait_for("retire prologue", 0);
    check_output("pc before beq", 64'(pm_addr_64), 64'h10);
    t0 = cyc; wait_for("retire beq", 0);
    check_output("lat beq", 64'(cyc - t0), 64'd3);
    check_output("beq target", 64'(pm_addr_64), 64'h08);
    prog_64[4] = 32'hFE109CE3;  // bne x1,x1,-8
    wait_for("retire nop 8", 0);
    wait_for("retire nop c", 0);
    t0 = cyc; wait_for("retire bne", 0);
    check_output("lat bne", 64'(cyc - t0), 64'd3);
    check_output("bne fallthrough", 64'(pm_addr_64), 64'h14);

    wait_for("retire addi x0", 0);
    wait_for("cs sd x0", 1);
    check_output("sd x0 data", dm_wdata_64, 64'd0);
    check_output("sd x0 addr", 64'(dm_addr_64), 64'd0);
    wait_for("retire sd x0", 0);

    check_output("pc illegal", 64'(pm_addr_64), 64'h1C);
    step();
    check_output("halt in decode", 64'(halt_64), 64'd0);
    step();
    check_output("halt set", 64'(halt_64), 64'd1);
    check_output("no retire on halt", 64'(retire_64), 64'd0);
    any_cs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      any_cs = any_cs | pm_cs_64 | dm_cs_64;
    end
    check_output("halt cs quiet", 64'(any_cs), 64'd0);
    check_output("halt sticky", 64'(halt_64), 64'd1);
    rst_64 = 1'b1;
    step();
    check_output("halt cleared", 64'(halt_64), 64'd0);
    check_output("reset pm_addr", 64'(pm_addr_64), 64'd0);
    check_output("reset pm_cs", 64'(pm_cs_64), 64'd1);

    check_output("x32 rst pm_cs", 64'(pm_cs_32), 64'd1);
    check_output("x32 rst dm_cs", 64'(dm_cs_32), 64'd0);
    rst_32 = 1'b0;
    t0 = cyc; wait_for("x32 retire addi", 2); check_output("x32 lat addi", 64'(cyc - t0), 64'd4);
    wait_for("x32 cs sw x1", 3);
    check_output("x32 sw x1 data", 64'(dm_wdata_32), 64'h0C000000);
    check_output("x32 sw x1 addr", 64'(dm_addr_32), 64'd4);
    check_output("x32 sw x1 rw", 64'(dm_rw_32), 64'd1);
    wait_for("x32 retire sw x1", 2);
    t0 = cyc; wait_for("x32 cs lw", 3);
    check_output("x32 lw rw", 64'(dm_rw_32), 64'd0);
    wait_for("x32 retire lw", 2); check_output("x32 lat lw", 64'(cyc - t0), 64'd5);
    wait_for("x32 cs sw x2", 3);
    check_output("x32 sw x2 data", 64'(dm_wdata_32), 64'h0C000000);
    check_output("x32 sw x2 addr", 64'(dm_addr_32), 64'd8);
    wait_for("x32 retire sw x2", 2);
    step(); step();
    check_output("x32 ld halts", 64'(halt_32), 64'd1);

    // Reset lands while a store is stalled in MEM.
    rst_32 = 1'b1;
    step();
    rst_32 = 1'b0; dm_ready_32 = 1'b0;
    wait_for("x32 retire addi 2", 2);
    wait_for("x32 cs stalled sw", 3);
    step();
    check_output("x32 stalled cs", 64'(dm_cs_32), 64'd1);
    rst_32 = 1'b1;
    step();
    check_output("x32 abort dm_cs", 64'(dm_cs_32), 64'd0);
    check_output("x32 abort pm_cs", 64'(pm_cs_32), 64'd1);
    check_output("x32 abort pm_addr", 64'(pm_addr_32), 64'd0);
    check_output("x32 abort halt", 64'(halt_32), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
